alu_addsub_pipe: RTL and testbench

- Parametrised, pipelined integer ALU for the Y86-64 execute stage. Successor to the flat 64-bit add/sub path.
- Implements addq, subq, andq and xorq over WIDTH bits. The carry chain is split into CHUNK-bit slices, with one pipeline stage per slice.
- Produces the result plus the condition codes ZF, SF and OF.
- Valid/ready handshake on both sides, plus a flush input for misprediction squash.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_slice.sv | 32 +++
 rtl/alu_addsub_pipe.sv | 160 ++++++++++++++++
 tb/tb_alu_addsub_pipe.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the pipelined Y86-64 ALU: function encoding, condition codes
// and the overflow rule used at the end of the pipeline.
package alu_pkg;

  typedef enum logic [1:0] {
    FN_ADD = 2'd0,
    FN_SUB = 2'd1,
    FN_AND = 2'd2,
    FN_XOR = 2'd3
  } alu_fn_t;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  // Signed overflow from operand and result sign bits; logic ops never overflow.
  function automatic logic calc_of(alu_fn_t fn, logic a_msb, logic b_msb, logic r_msb);
    logic ovf;
    ovf = 1'b0;
    case (fn)
      FN_ADD:  ovf = (a_msb == b_msb) && (r_msb != a_msb);
      FN_SUB:  ovf = (a_msb != b_msb) && (r_msb != a_msb);
      default: ovf = 1'b0;
    endcase
    return ovf;
  endfunction

endpackage

// File: rtl/alu_slice.sv
// One CHUNK-bit slice of the ALU datapath: add/sub with carry in/out, or a
// bitwise and/xor. Purely combinational; the parent registers its outputs.
module alu_slice
  import alu_pkg::*;
#(
  parameter int CHUNK = 16
) (
  input  alu_fn_t          fn,
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] r,
  output logic             cout
);

  logic [CHUNK-1:0] b_eff;
  logic [CHUNK:0]   sum;

  // Subtraction inverts b here; the +1 arrives as the carry into slice 0.
  always_comb begin
    b_eff = (fn == FN_SUB) ? ~b : b;
    sum   = {1'b0, a} + {1'b0, b_eff} + {{CHUNK{1'b0}}, cin};
    r     = '0;
    cout  = 1'b0;
    case (fn)
      FN_ADD, FN_SUB: {cout, r} = sum;
      FN_AND:         r = a & b;
      default:        r = a ^ b;
    endcase
  end

endmodule

// File: rtl/alu_addsub_pipe.sv
// Pipelined add/sub/and/xor ALU, one CHUNK-bit carry slice per stage, with
// valid/ready handshake and flush. Define ALU_CF_EN to add the out_cf output.
module alu_addsub_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_fn,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zf,
  output logic             out_sf,
`ifdef ALU_CF_EN
  output logic             out_cf,
`endif
  output logic             out_of
);

  localparam int NSTAGE = WIDTH / CHUNK;
  localparam int LAST   = NSTAGE - 1;
  localparam int CQW    = (NSTAGE > 1) ? NSTAGE - 1 : 1;

  logic [NSTAGE-1:0] vld, nv;
  logic [NSTAGE-1:0] z_q, nz, nc;
  logic [CQW-1:0]    c_q;
  alu_fn_t           fn_q [NSTAGE];
  alu_fn_t           nfn  [NSTAGE];
  logic [WIDTH-1:0]  a_q  [NSTAGE];
  logic [WIDTH-1:0]  b_q  [NSTAGE];
  logic [WIDTH-1:0]  r_q  [NSTAGE];
  logic [WIDTH-1:0]  na   [NSTAGE];
  logic [WIDTH-1:0]  nb   [NSTAGE];
  logic [WIDTH-1:0]  nr   [NSTAGE];
  logic              en;
  cc_t               cc;

  assign en        = !out_valid || out_ready;
  assign in_ready  = en;
  assign out_valid = vld[LAST];

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    alu_fn_t          sfn;
    logic [WIDTH-1:0] sa, sb, sr, mr;
    logic             scin, sz, slc;
    logic [CHUNK-1:0] slr;

    if (k == 0) begin : g_first
      assign sfn   = alu_fn_t'(in_fn);
      assign sa    = in_a;
      assign sb    = in_b;
      assign sr    = '0;
      assign scin  = (alu_fn_t'(in_fn) == FN_SUB);
      assign sz    = 1'b1;
      assign nv[k] = in_valid;
    end else begin : g_next
      assign sfn   = fn_q[k-1];
      assign sa    = a_q[k-1];
      assign sb    = b_q[k-1];
      assign sr    = r_q[k-1];
      assign scin  = c_q[k-1];
      assign sz    = z_q[k-1];
      assign nv[k] = vld[k-1];
    end

    alu_slice #(.CHUNK(CHUNK)) u_slice (
      .fn   (sfn),
      .a    (sa[k*CHUNK +: CHUNK]),
      .b    (sb[k*CHUNK +: CHUNK]),
      .cin  (scin),
      .r    (slr),
      .cout (slc)
    );

    // Splice this stage's slice into the partial result carried so far.
    always_comb begin
      mr                     = sr;
      mr[k*CHUNK +: CHUNK]   = slr;
    end

    assign nfn[k] = sfn;
    assign na[k]  = sa;
    assign nb[k]  = sb;
    assign nr[k]  = mr;
    assign nz[k]  = sz & (slr == '0);
    assign nc[k]  = slc;
  end

  // Flush clears only valid bits; data may go stale since nothing reads it.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      z_q <= '0;
      c_q <= '0;
      for (int k = 0; k < NSTAGE; k++) begin
        fn_q[k] <= FN_ADD;
        a_q[k]  <= '0;
        b_q[k]  <= '0;
        r_q[k]  <= '0;
      end
    end else begin
      if (flush)
        vld <= '0;
      else if (en)
        vld <= nv;
      if (en) begin
        z_q <= nz;
        for (int k = 0; k < NSTAGE; k++) begin
          fn_q[k] <= nfn[k];
          a_q[k]  <= na[k];
          b_q[k]  <= nb[k];
          r_q[k]  <= nr[k];
        end
        for (int k = 0; k < NSTAGE - 1; k++)
          c_q[k] <= nc[k];
      end
    end
  end

  always_comb begin
    cc.zf = z_q[LAST];
    cc.sf = r_q[LAST][WIDTH-1];
    cc.of = calc_of(fn_q[LAST], a_q[LAST][WIDTH-1], b_q[LAST][WIDTH-1], r_q[LAST][WIDTH-1]);
  end

  assign out_result = r_q[LAST];
  assign out_zf     = cc.zf;
  assign out_sf     = cc.sf;
  assign out_of     = cc.of;

`ifdef ALU_CF_EN
  logic cf_q;

  // Carry out of the top slice; subtraction reports it inverted as a borrow.
  always_ff @(posedge clk) begin
    if (rst)
      cf_q <= 1'b0;
    else if (en)
      cf_q <= nc[LAST];
  end

  always_comb begin
    out_cf = 1'b0;
    case (fn_q[LAST])
      FN_ADD:  out_cf = cf_q;
      FN_SUB:  out_cf = ~cf_q;
      default: out_cf = 1'b0;
    endcase
  end
`endif

endmodule

// File: tb/tb_alu_addsub_pipe.sv
// Self-checking bench for alu_addsub_pipe: directed vector table plus stall,
// flush and reset sequences on a 64/16 and a 32/32 instance.
module tb_alu_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  in_fn;
  logic [63:0] in_a, in_b, out_result;
  logic        out_zf, out_sf, out_of, out_cf;

  logic        v1, rdy1, ovld1, ordy1;
  logic [1:0]  fn1;
  logic [31:0] a1, b1, res1;
  logic        zf1, sf1, of1, cf1;

  int passes = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_addsub_pipe #(.WIDTH(64), .CHUNK(16)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_fn(in_fn), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zf(out_zf), .out_sf(out_sf),
`ifdef ALU_CF_EN
    .out_cf(out_cf),
`endif
    .out_of(out_of)
  );

  alu_addsub_pipe #(.WIDTH(32), .CHUNK(32)) dut1 (
    .clk(clk), .rst(rst), .flush(1'b0),
    .in_valid(v1), .in_ready(rdy1), .in_fn(fn1), .in_a(a1), .in_b(b1),
    .out_valid(ovld1), .out_ready(ordy1), .out_result(res1),
    .out_zf(zf1), .out_sf(sf1),
`ifdef ALU_CF_EN
    .out_cf(cf1),
`endif
    .out_of(of1)
  );

`ifndef ALU_CF_EN
  assign out_cf = 1'b0;
  assign cf1    = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [1:0]  fn;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] r;
    logic        zf;
    logic        sf;
    logic        of;
    logic        cf;
  } vec_t;

  vec_t vecs[11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp)
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    else
      passes++;
  endtask

  task automatic applyStimulus(input vec_t v);
    int cnt;
    in_fn     = v.fn;
    in_a      = v.a;
    in_b      = v.b;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    cnt = 1;
    while (!out_valid && cnt < 20) begin
      tick();
      cnt++;
    end
    checkOutput({v.name, " latency"}, 64'(cnt), 64'd4);
    checkOutput({v.name, " result"}, out_result, v.r);
    checkOutput({v.name, " zf"}, 64'(out_zf), 64'(v.zf));
    checkOutput({v.name, " sf"}, 64'(out_sf), 64'(v.sf));
    checkOutput({v.name, " of"}, 64'(out_of), 64'(v.of));
`ifdef ALU_CF_EN
    checkOutput({v.name, " cf"}, 64'(out_cf), 64'(v.cf));
`endif
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] expq[$];
    logic [63:0] held, ea, eb;
    logic        stalled;
    int          sent, rcvd, cyc, seen;

    vecs[0]  = '{"add max+1",   2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{"sub 5-5",     2'd1, 64'd5, 64'd5, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{"sub 0-1",     2'd1, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{"add carry",   2'd0, 64'h0000_FFFF_FFFF_FFFF, 64'd1, 64'h0001_0000_0000_0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{"sub min-1",   2'd1, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{"and",         2'd2, 64'hFF00_FF00_FF00_FF00, 64'h0FF0_0FF0_0FF0_0FF0, 64'h0F00_0F00_0F00_0F00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{"xor self",    2'd3, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{"add wrap",    2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{"add min+min", 2'd0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[9]  = '{"sub 1-2",     2'd1, 64'd1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{"xor post-flush", 2'd3, 64'hF0, 64'hFF, 64'h0F, 1'b0, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_fn = 2'd0; in_a = '0; in_b = '0;
    v1 = 1'b0; ordy1 = 1'b1; fn1 = 2'd0; a1 = '0; b1 = '0;
    repeat (3) tick();
    rst = 1'b0;
    #1;

    checkOutput("reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset out_result", out_result, 64'd0);
    checkOutput("reset flags", {61'd0, out_zf, out_sf, out_of}, 64'd0);
    checkOutput("reset cf", 64'(out_cf), 64'd0);
    checkOutput("reset in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset dut1 out_valid", 64'(ovld1), 64'd0);

    for (int i = 0; i < 10; i++)
      applyStimulus(vecs[i]);

    // Back-to-back stream with the consumer stalled for cycles 3-6.
    for (int i = 0; i < 10; i++) begin
      ea = 64'h0000_FFFF_FFFF_0000 + 64'(i) * 64'h1_0001;
      eb = 64'(i) * 64'h1234_5678 + 64'hFFFF;
      expq.push_back((i % 2 == 1) ? ea - eb : ea + eb);
    end
    sent = 0; rcvd = 0; cyc = 0; stalled = 1'b0; held = '0;
    while (rcvd < 10 && cyc < 60) begin
      out_ready = !(cyc >= 3 && cyc <= 6);
      if (sent < 10) begin
        in_valid = 1'b1;
        in_fn    = (sent % 2 == 1) ? 2'd1 : 2'd0;
        in_a     = 64'h0000_FFFF_FFFF_0000 + 64'(sent) * 64'h1_0001;
        in_b     = 64'(sent) * 64'h1234_5678 + 64'hFFFF;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (stalled)
        checkOutput("stall hold", out_result, held);
      stalled = out_valid && !out_ready;
      held    = out_result;
      if (out_valid && out_ready) begin
        checkOutput($sformatf("b2b beat %0d", rcvd), out_result, expq.pop_front());
        rcvd++;
      end
      if (in_valid && in_ready)
        sent++;
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checkOutput("b2b count", 64'(rcvd), 64'd10);
    repeat (6) tick();
    checkOutput("b2b no extra", 64'(out_valid), 64'd0);

    // Three beats in flight, then flush together with a fourth beat.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_fn = 2'd0; in_a = 64'(i + 1); in_b = 64'd7;
      tick();
    end
    flush = 1'b1;
    in_a  = 64'd99;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    seen = 0;
    repeat (8) begin
      if (out_valid) seen++;
      tick();
    end
    checkOutput("flush no output", 64'(seen), 64'd0);
    applyStimulus(vecs[10]);

    // Single-stage instance, then reset in the middle of a stream.
    in_valid = 1'b1; in_fn = 2'd0; in_a = 64'd3; in_b = 64'd4;
    v1 = 1'b1; fn1 = 2'd2; a1 = 32'hFFFF_0000; b1 = 32'h0F0F_0F0F;
    tick();
    in_valid = 1'b0;
    checkOutput("w32 out_valid", 64'(ovld1), 64'd1);
    checkOutput("w32 and result", 64'(res1), 64'h0F0F_0000);
    checkOutput("w32 flags", {61'd0, zf1, sf1, of1}, 64'd0);
    checkOutput("w32 cf", 64'(cf1), 64'd0);
    rst = 1'b1;
    tick();
    checkOutput("rst dut1 out_valid", 64'(ovld1), 64'd0);
    checkOutput("rst dut1 result", 64'(res1), 64'd0);
    rst = 1'b0; v1 = 1'b0;
    #1;
    checkOutput("rst in_ready", 64'(in_ready), 64'd1);
    seen = 0;
    repeat (6) begin
      if (out_valid) seen++;
      tick();
    end
    checkOutput("rst discards in-flight", 64'(seen), 64'd0);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
